shiftreg_in: RTL and testbench

SHIFTREG_IN -- requirements
Module: shiftreg_in

---
 rtl/shiftreg_pkg.sv | 16 +
 rtl/shiftreg_in_bit_counter.sv | 31 +++
 rtl/shiftreg_in.sv | 110 +++++++++++
 tb/tb_shiftreg_in.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/shiftreg_pkg.sv
// Shared types and serializer-facing constants for the serial-in word assembler.
package shiftreg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // The serializer loads its word in the cycle start is seen and presents
  // bit 0 on the following cycle, LSB first.
  localparam int SER_DEFAULT_WIDTH   = 4;
  localparam bit SER_LSB_FIRST       = 1'b1;
  localparam int SER_FIRST_BIT_DELAY = 1;

endpackage

// File: rtl/shiftreg_in_bit_counter.sv
// Bit counter for shiftreg_in: synchronous clear, increment, and a terminal
// flag that is high while the last bit of the word is being captured.
module bit_counter #(
  parameter int WIDTH = 4
) (
  input  logic clk,
  input  logic rstb,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)      cnt_d = '0;
    else if (inc) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // CW bits hold WIDTH itself, so the count parks at WIDTH without wrapping.
  assign tc = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/shiftreg_in.sv
// Serial-in, LSB-first word assembler with IDLE/SHIFT/DONE control.
// Optional even parity tracking enabled by defining SHIFTREG_IN_PARITY_EN.
module shiftreg_in
  import shiftreg_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             ena,
  input  logic             clear,
  input  logic             start,
  input  logic             A_bit,
  output logic [WIDTH-1:0] A,
  output logic             busy,
  output logic             done,
  output logic             parity
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic             cnt_clr, cnt_inc, cnt_tc;
  logic             restart, capture;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    restart = 1'b0;
    capture = 1'b0;
    if (ena) begin
      if (!clear) begin
        state_d = IDLE;
        a_d     = '0;
        cnt_clr = 1'b1;
        restart = 1'b1;
      end else begin
        unique case (state_q)
          IDLE, DONE: begin
            // DONE falls back to IDLE unless a new word starts immediately.
            state_d = IDLE;
            if (start) begin
              state_d = SHIFT;
              a_d     = '0;
              cnt_clr = 1'b1;
              restart = 1'b1;
            end
          end
          SHIFT: begin
            a_d     = {A_bit, a_q[WIDTH-1:1]};
            cnt_inc = 1'b1;
            capture = 1'b1;
            if (cnt_tc) state_d = DONE;
          end
          default: begin
            state_d = IDLE;
            a_d     = '0;
            cnt_clr = 1'b1;
            restart = 1'b1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= IDLE;
      a_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
    end
  end

  bit_counter #(.WIDTH(WIDTH)) u_bit_counter (
    .clk  (clk),
    .rstb (rstb),
    .clr  (cnt_clr),
    .inc  (cnt_inc),
    .tc   (cnt_tc)
  );

`ifdef SHIFTREG_IN_PARITY_EN
  logic par_q, par_d;

  always_comb begin
    par_d = par_q;
    if (restart)      par_d = 1'b0;
    else if (capture) par_d = par_q ^ A_bit;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) par_q <= 1'b0;
    else       par_q <= par_d;
  end

  assign parity = par_q;
`else
  logic unused_par;
  assign unused_par = restart ^ capture;
  assign parity     = 1'b0;
`endif

  assign A    = a_q;
  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_shiftreg_in.sv
// Randomized and directed bench for shiftreg_in (WIDTH=4 model-checked,
// WIDTH=8 fed by a behavioural LSB-first serializer).
module tb_shiftreg_in;

  logic       clk = 1'b0;
  logic       rstb;
  logic       ena, clear, start, a_bit;
  logic [3:0] a4;
  logic       busy4, done4, par4;

  logic       start8;
  logic [7:0] a8, ser_q, ser_word;
  logic       busy8, done8, par8;

  int checks = 0;
  int errors = 0;

  // Reference model state: what has been collected since the last start.
  bit         m_collecting, m_complete, m_par;
  int         m_nbits;
  logic [3:0] m_word;

  always #5 clk = ~clk;

  shiftreg_in #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rstb(rstb), .ena(ena), .clear(clear), .start(start),
    .A_bit(a_bit), .A(a4), .busy(busy4), .done(done4), .parity(par4)
  );

  shiftreg_in #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rstb(rstb), .ena(1'b1), .clear(1'b1), .start(start8),
    .A_bit(ser_q[0]), .A(a8), .busy(busy8), .done(done8), .parity(par8)
  );

  // Serializer: loads in the start cycle, then shifts out LSB first.
  always @(posedge clk) ser_q <= start8 ? ser_word : {1'b0, ser_q[7:1]};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit exp_par();
`ifdef SHIFTREG_IN_PARITY_EN
    return m_par;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    m_collecting = 0; m_complete = 0; m_par = 0; m_nbits = 0; m_word = '0;
  endtask

  task automatic model_step(input bit e, input bit c, input bit s, input bit b);
    if (!e) return;
    if (!c) begin
      model_reset();
    end else if (m_collecting) begin
      m_word = {b, m_word[3:1]};
      m_par  = m_par ^ b;
      m_nbits++;
      m_complete = 0;
      if (m_nbits == 4) begin
        m_collecting = 0;
        m_complete   = 1;
      end
    end else if (s) begin
      m_collecting = 1; m_complete = 0; m_word = '0; m_par = 0; m_nbits = 0;
    end else begin
      m_complete = 0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".A"},      a4,    m_word);
    chk({tag, ".busy"},   busy4, m_collecting);
    chk({tag, ".done"},   done4, m_complete);
    chk({tag, ".parity"}, par4,  exp_par());
  endtask

  // Called at a negedge: drive, let one rising edge pass, check at next negedge.
  task automatic cyc(input bit e, input bit c, input bit s, input bit b, input string tag);
    ena = e; clear = c; start = s; a_bit = b;
    @(posedge clk);
    model_step(e, c, s, b);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic send4(input logic [3:0] w, input string tag);
    for (int i = 0; i < 4; i++) cyc(1, 1, 0, w[i], tag);
  endtask

  initial begin
    logic [3:0] w;
    rstb = 1'b0; ena = 0; clear = 1; start = 0; a_bit = 0;
    start8 = 0; ser_word = '0;
    model_reset();
    #12;
    check_all("reset");
    chk("reset.A8", a8, 8'h00);
    chk("reset.busy8", busy8, 1'b0);
    @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);

    // Basic word 1,0,1,1 -> 4'b1101
    cyc(1, 1, 1, 1, "start");
    w = 4'b1101;
    send4(w, "w1101");
    chk("w1101.done_final", done4, 1'b1);
    chk("w1101.word", a4, 4'b1101);
    cyc(1, 1, 0, 0, "done_to_idle");
    cyc(1, 1, 0, 1, "idle_hold");

    // Enable stall mid-word
    cyc(1, 1, 1, 0, "stall.start");
    cyc(1, 1, 0, 1, "stall.b0");
    cyc(1, 1, 0, 1, "stall.b1");
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, "stall.hold");
    cyc(1, 1, 0, 0, "stall.b2");
    cyc(1, 1, 0, 1, "stall.b3");
    chk("stall.word", a4, 4'b1011);

    // Back-to-back: start in DONE, next bits 0,0,0,1
    cyc(1, 1, 1, 1, "b2b.start_in_done");
    chk("b2b.busy_no_gap", busy4, 1'b1);
    w = 4'b1000;
    send4(w, "b2b");
    chk("b2b.word", a4, 4'b1000);

    // Clear wins over start during SHIFT
    cyc(1, 1, 0, 0, "clr.idle");
    cyc(1, 1, 1, 0, "clr.start");
    cyc(1, 1, 0, 1, "clr.b0");
    cyc(1, 0, 1, 1, "clr.clear");
    chk("clr.A_zero", a4, 4'h0);
    for (int i = 0; i < 5; i++) cyc(1, 1, 0, 1, "clr.no_done");

    // Asynchronous reset mid-word, between edges
    cyc(1, 1, 1, 0, "ar.start");
    cyc(1, 1, 0, 1, "ar.b0");
    cyc(1, 1, 0, 1, "ar.b1");
    cyc(1, 1, 0, 1, "ar.b2");
    #2 rstb = 1'b0;
    #1;
    model_reset();
    chk("ar.A_now", a4, 4'h0);
    chk("ar.busy_now", busy4, 1'b0);
    chk("ar.done_now", done4, 1'b0);
    @(negedge clk);
    rstb = 1'b1;
    for (int i = 0; i < 6; i++) cyc(1, 1, 0, 1, "ar.no_done");

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 7) != 0), ($urandom_range(0, 19) != 0),
          ($urandom_range(0, 2) == 0), $urandom_range(0, 1), "rand");
    end

    // WIDTH=8 via serializer
    for (int n = 0; n < 3; n++) begin
      ser_word = (n == 0) ? 8'hA5 : 8'($urandom);
      start8 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start8 = 1'b0;
      chk("w8.busy_after_start", busy8, 1'b1);
      for (int i = 0; i < 8; i++) begin
        @(posedge clk);
        @(negedge clk);
        chk("w8.done_timing", done8, (i == 7));
      end
      chk("w8.word", a8, ser_word);
`ifdef SHIFTREG_IN_PARITY_EN
      chk("w8.parity", par8, ^ser_word);
`else
      chk("w8.parity", par8, 1'b0);
`endif
      @(posedge clk);
      @(negedge clk);
      chk("w8.idle_hold", a8, ser_word);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
